// File: rtl/ifu_fetch_seq.sv
// Fetch sequencer: produces group-aligned IMEM requests and queues the returned
// fetch groups for IDU. Redirects use an epoch bit to discard stale responses.
`timescale 1ns/1ps
module ifu_fetch_seq #(
  parameter int PC_W      = 32,
  parameter int INST_W    = 32,
  parameter int FETCH_W   = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_pulse,
  input  logic [PC_W-1:0]           start_pc,
  input  logic                      core_running,
  input  logic                      wfi_req,
  input  logic                      bru_flush,
  input  logic [PC_W-1:0]           bru_redir_pc,
  output logic                      imem_req,
  output logic [PC_W-1:0]           imem_addr,
  input  logic [FETCH_W*INST_W-1:0] imem_rdata,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [PC_W-1:0]           out_pc,
  output logic [FETCH_W-1:0]        out_slot_vld,
  output logic [FETCH_W*INST_W-1:0] out_inst,
  output logic                      out_pc_unalign,
  output logic                      idle
);

  localparam int OFF_W = $clog2(FETCH_W*4);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH+1);
  localparam logic [PC_W-1:0] STEP  = PC_W'(FETCH_W*4);
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(FETCH_W*4-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                    state, state_nxt;
  logic [PC_W-1:0]           fpc, fpc_nxt, sel_pc, req_pc;
  logic                      epoch, inflight, req_epoch;
  logic [FETCH_W-1:0]        sel_mask, req_mask;
  logic [OFF_W-1:0]          slot_idx;
  logic                      redirect, unalign, issue, pop, push;
  logic [CNT_W:0]            occupancy;
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [PC_W-1:0]           q_pc   [BUF_DEPTH];
  logic [FETCH_W-1:0]        q_mask [BUF_DEPTH];
  logic [FETCH_W*INST_W-1:0] q_inst [BUF_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue decision: a redirect treats the queue and in-flight slot as already empty.
  always_comb begin
    redirect  = start_pulse | bru_flush;
    sel_pc    = start_pulse ? start_pc : (bru_flush ? bru_redir_pc : fpc);
    imem_addr = sel_pc & ALIGN;
    unalign   = (sel_pc[1:0] != 2'b00);
    slot_idx  = sel_pc[OFF_W-1:0] >> 2;
    for (int i = 0; i < FETCH_W; i++) sel_mask[i] = (i >= int'(slot_idx));
    pop       = out_vld & out_rdy & ~redirect;
    push      = inflight & (req_epoch == epoch) & ~redirect;
    occupancy = redirect ? '0
              : (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    issue     = ((state == S_RUN) | redirect) & (core_running | start_pulse)
              & (~wfi_req | redirect) & (occupancy < (CNT_W+1)'(BUF_DEPTH));
    imem_req  = issue;
  end

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    if (issue & unalign)                 state_nxt = S_HALT;
    else if (redirect)                   state_nxt = S_RUN;
    else if (state == S_RUN && wfi_req)  state_nxt = S_HALT;
    // A redirect that cannot issue yet still remembers its target.
    if (issue & ~unalign)                fpc_nxt = imem_addr + STEP;
    else if (redirect)                   fpc_nxt = sel_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fpc       <= '0;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      req_epoch <= 1'b0;
      req_pc    <= '0;
      req_mask  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      inflight <= issue;
      if (redirect) epoch <= ~epoch;
      if (issue) begin
        req_pc    <= sel_pc;
        req_mask  <= sel_mask;
        req_epoch <= epoch ^ redirect;
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_mask[wr_ptr] <= req_mask;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  always_comb begin
    out_vld        = (count != '0);
    out_pc         = out_vld ? q_pc[rd_ptr]   : '0;
    out_slot_vld   = out_vld ? q_mask[rd_ptr] : '0;
    out_inst       = out_vld ? q_inst[rd_ptr] : '0;
    out_pc_unalign = out_vld & (out_pc[1:0] != 2'b00);
    idle           = (state != S_RUN) & (count == '0) & ~inflight;
  end

endmodule

// File: tb/tb_ifu_fetch_seq.sv
// Self-checking bench for ifu_fetch_seq: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_ifu_fetch_seq;

  localparam int FW    = 2;
  localparam int FW4   = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // FETCH_W=2 instance
  logic          start_pulse, core_running, wfi_req, bru_flush, out_rdy;
  logic [31:0]   start_pc, bru_redir_pc;
  logic          imem_req, out_vld, out_pc_unalign, idle;
  logic [31:0]   imem_addr, out_pc, mem_addr_q;
  logic [FW-1:0] out_slot_vld;
  logic [FW*32-1:0] imem_rdata, out_inst;

  // FETCH_W=4 instance
  logic           start_pulse4, core_running4, wfi_req4, bru_flush4, out_rdy4;
  logic [31:0]    start_pc4, bru_redir_pc4;
  logic           imem_req4, out_vld4, out_pc_unalign4, idle4;
  logic [31:0]    imem_addr4, out_pc4, mem_addr_q4;
  logic [FW4-1:0] out_slot_vld4;
  logic [FW4*32-1:0] imem_rdata4, out_inst4;

  ifu_fetch_seq #(.PC_W(32), .INST_W(32), .FETCH_W(FW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .start_pc(start_pc),
    .core_running(core_running), .wfi_req(wfi_req), .bru_flush(bru_flush),
    .bru_redir_pc(bru_redir_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_vld(out_vld), .out_rdy(out_rdy), .out_pc(out_pc),
    .out_slot_vld(out_slot_vld), .out_inst(out_inst), .out_pc_unalign(out_pc_unalign),
    .idle(idle)
  );

  ifu_fetch_seq #(.PC_W(32), .INST_W(32), .FETCH_W(FW4), .BUF_DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse4), .start_pc(start_pc4),
    .core_running(core_running4), .wfi_req(wfi_req4), .bru_flush(bru_flush4),
    .bru_redir_pc(bru_redir_pc4), .imem_req(imem_req4), .imem_addr(imem_addr4),
    .imem_rdata(imem_rdata4), .out_vld(out_vld4), .out_rdy(out_rdy4), .out_pc(out_pc4),
    .out_slot_vld(out_slot_vld4), .out_inst(out_inst4), .out_pc_unalign(out_pc_unalign4),
    .idle(idle4)
  );

  // Instruction memory contents are a fixed function of the word address.
  function automatic logic [31:0] gen_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ a[15:0]};
  endfunction

  function automatic logic [FW*32-1:0] group2(input logic [31:0] aligned);
    logic [FW*32-1:0] g;
    for (int i = 0; i < FW; i++) g[i*32 +: 32] = gen_word(aligned + 32'(i*4));
    return g;
  endfunction

  function automatic logic [FW-1:0] mask_of(input logic [31:0] pc);
    logic [FW-1:0] m;
    int idx;
    idx = int'((pc % 32'(FW*4)) / 32'd4);
    m = '0;
    for (int i = 0; i < FW; i++) if (i >= idx) m[i] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin
    mem_addr_q  <= imem_addr;
    mem_addr_q4 <= imem_addr4;
  end

  always_comb begin
    for (int i = 0; i < FW; i++)  imem_rdata[i*32 +: 32]  = gen_word(mem_addr_q + 32'(i*4));
    for (int i = 0; i < FW4; i++) imem_rdata4[i*32 +: 32] = gen_word(mem_addr_q4 + 32'(i*4));
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the queue holds only the PC of each delivered group; the
  // mask, data and unaligned flag of an entry follow from that PC.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_pend_pc, m_fpc;
  logic [31:0] mq[$];

  bit          e_red, e_pop, e_wfi;
  logic [31:0] e_sel;
  logic        exp_req, exp_vld, exp_unal, exp_idle;
  logic [31:0] exp_addr, exp_pc;
  logic [FW-1:0]    exp_mask;
  logic [FW*32-1:0] exp_inst;
  bit chk_en = 0;

  task automatic modelReset();
    mq.delete();
    m_pend = 0;
    m_pend_pc = '0;
    m_fpc = '0;
    m_mode = M_IDLE;
  endtask

  task automatic modelEval();
    int occ;
    e_red    = start_pulse || bru_flush;
    e_sel    = start_pulse ? start_pc : (bru_flush ? bru_redir_pc : m_fpc);
    e_wfi    = wfi_req;
    exp_addr = (e_sel / 32'(FW*4)) * 32'(FW*4);
    exp_vld  = (mq.size() != 0);
    if (exp_vld) begin
      exp_pc   = mq[0];
      exp_mask = mask_of(mq[0]);
      exp_inst = group2((mq[0] / 32'(FW*4)) * 32'(FW*4));
      exp_unal = (mq[0] % 4) != 0;
    end
    e_pop    = exp_vld && out_rdy && !e_red;
    occ      = e_red ? 0 : mq.size() + int'(m_pend) - int'(e_pop);
    exp_req  = (m_mode == M_RUN || e_red) && (core_running || start_pulse)
               && (!wfi_req || e_red) && (occ < DEPTH);
    exp_idle = (m_mode != M_RUN) && (mq.size() == 0) && !m_pend;
  endtask

  task automatic modelCommit();
    if (e_red) mq.delete();
    else begin
      if (e_pop) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_pc);
    end
    if (exp_req && (e_sel % 4) != 0)   m_mode = M_HALT;
    else if (e_red)                    m_mode = M_RUN;
    else if (m_mode == M_RUN && e_wfi) m_mode = M_HALT;
    if (exp_req && (e_sel % 4) == 0) m_fpc = exp_addr + 32'(FW*4);
    else if (e_red)                  m_fpc = e_sel;
    m_pend    = exp_req;
    m_pend_pc = e_sel;
  endtask

  task automatic checkOutput();
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("out_vld", out_vld, exp_vld);
    if (exp_vld) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_slot_vld", out_slot_vld, exp_mask);
      chk("out_inst", out_inst, exp_inst);
      chk("out_pc_unalign", out_pc_unalign, exp_unal);
    end
    chk("idle", idle, exp_idle);
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  // Drives one cycle of inputs (called just after a rising edge) and waits for the
  // falling edge, where outputs are stable.
  task automatic applyStimulus(input logic st, input logic [31:0] spc, input logic cr,
                               input logic wfi, input logic fl, input logic [31:0] rpc,
                               input logic rdy);
    start_pulse  = st;
    start_pc     = spc;
    core_running = cr;
    wfi_req      = wfi;
    bru_flush    = fl;
    bru_redir_pc = rpc;
    out_rdy      = rdy;
    modelEval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 1);
      tick();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_out_vld"}, out_vld, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_slot_vld"}, out_slot_vld, 0);
    chk({tag, "_out_inst"}, out_inst, 0);
    chk({tag, "_out_pc_unalign"}, out_pc_unalign, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  function automatic logic [31:0] rand_pc(input logic [31:0] base);
    logic [31:0] p;
    p = base + 32'($urandom_range(0, 255) * 4);
    if ($urandom_range(0, 7) == 0)  p = p + 32'd2;
    if ($urandom_range(0, 31) == 0) p = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
    return p;
  endfunction

  initial begin
    rst_n = 1'b0;
    {start_pulse, core_running, wfi_req, bru_flush, out_rdy} = '0;
    start_pc = '0; bru_redir_pc = '0;
    {start_pulse4, core_running4, wfi_req4, bru_flush4, out_rdy4} = '0;
    start_pc4 = '0; bru_redir_pc4 = '0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FETCH_W=4: address wrap past the top of the PC space and a mid-group entry.
    start_pulse4 = 1; start_pc4 = 32'hFFFF_FFF0; core_running4 = 1; out_rdy4 = 1;
    @(negedge clk);
    chk("w4_addr0", imem_addr4, 32'hFFFF_FFF0);
    @(posedge clk); #1; start_pulse4 = 0;
    @(negedge clk);
    chk("w4_addr_wrap", imem_addr4, 32'h0000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w4_out_vld", out_vld4, 1);
    chk("w4_out_pc0", out_pc4, 32'hFFFF_FFF0);
    chk("w4_mask0", out_slot_vld4, 4'b1111);
    chk("w4_inst0", out_inst4[31:0], gen_word(32'hFFFF_FFF0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("w4_out_pc1", out_pc4, 32'h0);
    @(posedge clk); #1;
    start_pulse4 = 1; start_pc4 = 32'h108;
    @(negedge clk);
    chk("w4_mid_addr", imem_addr4, 32'h100);
    @(posedge clk); #1; start_pulse4 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("w4_mid_pc", out_pc4, 32'h108);
    chk("w4_mid_mask", out_slot_vld4, 4'b1100);
    @(posedge clk); #1;
    core_running4 = 0;

    chk_en = 1;

    // Straight-line fetch from 0x100.
    applyStimulus(1, 32'h100, 1, 0, 0, 0, 1); chk("t1_addr0", imem_addr, 32'h100); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1);       chk("t1_addr1", imem_addr, 32'h108); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    chk("t1_addr2", imem_addr, 32'h110);
    chk("t1_vld", out_vld, 1);
    chk("t1_pc0", out_pc, 32'h100);
    chk("t1_mask0", out_slot_vld, 2'b11);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t1_pc1", out_pc, 32'h108); tick();

    // Mid-group start at 0x104.
    applyStimulus(1, 32'h104, 1, 0, 0, 0, 1); chk("t2_addr0", imem_addr, 32'h100); tick();
    quiet(1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    chk("t2_pc0", out_pc, 32'h104);
    chk("t2_mask0", out_slot_vld, 2'b10);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    chk("t2_pc1", out_pc, 32'h108);
    chk("t2_mask1", out_slot_vld, 2'b11);
    tick();

    // Back-pressure for 5 cycles.
    quiet(2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      if (k == 4) begin
        chk("t3_stall_req", imem_req, 0);
        chk("t3_stall_vld", out_vld, 1);
      end
      tick();
    end
    quiet(6);

    // Flush while 0x118 is in flight and the queue holds 0x110.
    applyStimulus(1, 32'h100, 1, 0, 0, 0, 1); tick();
    quiet(3);
    applyStimulus(0, 0, 1, 0, 1, 32'h200, 1);
    chk("t4_flush_addr", imem_addr, 32'h200);
    chk("t4_head_before", out_pc, 32'h110);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t4_empty", out_vld, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t4_pc_new", out_pc, 32'h200); tick();

    // WFI halt, drain, resume; then an unaligned redirect.
    applyStimulus(0, 0, 1, 1, 0, 0, 1); chk("t5_wfi_req", imem_req, 0); tick();
    quiet(2);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    chk("t5_idle", idle, 1);
    chk("t5_halt_req", imem_req, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 1, 32'h300, 1); chk("t5_resume_addr", imem_addr, 32'h300); tick();
    quiet(1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t5_resume_pc", out_pc, 32'h300); tick();
    quiet(2);
    applyStimulus(0, 0, 1, 0, 1, 32'h302, 1);
    chk("t5_unal_req", imem_req, 1);
    chk("t5_unal_addr", imem_addr, 32'h300);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t5_unal_halt", imem_req, 0); tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    chk("t5_unal_pc", out_pc, 32'h302);
    chk("t5_unal_flag", out_pc_unalign, 1);
    chk("t5_unal_mask", out_slot_vld, 2'b11);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 1); chk("t5_unal_single", out_vld, 0); tick();

    // Randomized traffic, with one asynchronous reset in the middle.
    applyStimulus(1, 32'h1000, 1, 0, 0, 0, 1); tick();
    for (int n = 0; n < 3000; n++) begin
      logic st, fl;
      if (n == 1500) begin
        chk_en = 0;
        {start_pulse, core_running, wfi_req, bru_flush, out_rdy} = '0;
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        modelReset();
        chk_en = 1;
      end
      st = ($urandom_range(0, 39) == 0) || (m_mode == M_IDLE && $urandom_range(0, 3) == 0);
      fl = (m_mode != M_IDLE) && ($urandom_range(0, 11) == 0);
      applyStimulus(st, rand_pc(32'h1000), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 14) == 0), fl, rand_pc(32'h8000),
                    ($urandom_range(0, 9) < 7));
      tick();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
